branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined RV32I core. It predicts next-PC in Fetch and trains on branches and jumps resolved in Execute. It also reports mispredictions and the corrected PC so the hazard unit can flush Fetch and Decode. It generalises the core's current fixed "predict not-taken, resolve in Execute" scheme with configurable table depth, per-entry history, and performance counters.

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters: combinational
// next-PC lookup in Fetch, training and misprediction reporting from Execute.
module branch_predictor #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ENTRIES    = 16,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pcf,
    output logic                  predict_taken_f,
    output logic [DATA_WIDTH-1:0] predict_target_f,
    input  logic                  update_e,
    input  logic [DATA_WIDTH-1:0] pce,
    input  logic                  taken_e,
    input  logic [DATA_WIDTH-1:0] target_e,
    input  logic                  is_jump_e,
    input  logic                  predicted_taken_e,
    input  logic [DATA_WIDTH-1:0] predicted_target_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    input  logic                  flush_table,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    logic [ENTRIES-1:0]    valid_q;
    logic [1:0]            ctr_q [ENTRIES];
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Fetch-side lookup
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    assign idx_f            = pcf[IDX+1:2];
    assign tag_f            = pcf[DATA_WIDTH-1:IDX+2];
    assign hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign predict_taken_f  = hit_f && ctr_q[idx_f][1];
    assign predict_target_f = predict_taken_f ? tgt_q[idx_f] : pcf + DATA_WIDTH'(4);

    // Execute-side resolution
    logic [IDX-1:0]   idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;

    assign idx_e         = pce[IDX+1:2];
    assign tag_e         = pce[DATA_WIDTH-1:IDX+2];
    assign hit_e         = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign mispredict_e  = update_e && ((taken_e != predicted_taken_e) ||
                           (taken_e && (target_e != predicted_target_e)));
    assign redirect_pc_e = taken_e ? target_e : pce + DATA_WIDTH'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_STATE;
        end else begin
            if (update_e)     branch_count     <= cnt_sat_inc(branch_count);
            if (mispredict_e) mispredict_count <= cnt_sat_inc(mispredict_count);
            if (flush_table) begin
                valid_q <= '0;
                for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_STATE;
            end else if (update_e) begin
                if (hit_e) begin
                    if (!taken_e)       ctr_q[idx_e] <= ctr_dec(ctr_q[idx_e]);
                    else if (is_jump_e) ctr_q[idx_e] <= 2'b11;
                    else                ctr_q[idx_e] <= ctr_inc(ctr_q[idx_e]);
                end else if (taken_e) begin
                    valid_q[idx_e] <= 1'b1;
                    ctr_q[idx_e]   <= is_jump_e ? 2'b11 : 2'b10;
                end
            end
        end
    end

    // Tag/target payload is never reset; valid_q alone qualifies it
    always_ff @(posedge clk) begin
        if (rst && update_e && taken_e && !flush_table) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= target_e;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, aliasing, same-cycle
// update/lookup ordering and table flush.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        predict_taken_f;
    logic [31:0] predict_target_f;
    logic        update_e;
    logic [31:0] pce;
    logic        taken_e;
    logic [31:0] target_e;
    logic        is_jump_e;
    logic        predicted_taken_e;
    logic [31:0] predicted_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic        flush_table;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_total = 0;
    int n_pass  = 0;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .INIT_STATE(2'b01)) dut (
        .clk                (clk),
        .rst                (rst),
        .pcf                (pcf),
        .predict_taken_f    (predict_taken_f),
        .predict_target_f   (predict_target_f),
        .update_e           (update_e),
        .pce                (pce),
        .taken_e            (taken_e),
        .target_e           (target_e),
        .is_jump_e          (is_jump_e),
        .predicted_taken_e  (predicted_taken_e),
        .predicted_target_e (predicted_target_e),
        .mispredict_e       (mispredict_e),
        .redirect_pc_e      (redirect_pc_e),
        .flush_table        (flush_table),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        update_e           = 1'b0;
        flush_table        = 1'b0;
        pce                = '0;
        taken_e            = 1'b0;
        target_e           = '0;
        is_jump_e          = 1'b0;
        predicted_taken_e  = 1'b0;
        predicted_target_e = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic jmp, input logic ptk, input logic [31:0] ptgt);
        update_e           = 1'b1;
        pce                = pc;
        taken_e            = tk;
        target_e           = tgt;
        is_jump_e          = jmp;
        predicted_taken_e  = ptk;
        predicted_target_e = ptgt;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        pcf = pc;
        #1;
        check({tag, "_taken"},  {31'd0, predict_taken_f}, {31'd0, exp_tk});
        check({tag, "_target"}, predict_target_f, exp_tgt);
    endtask

    task automatic check_exec(input string tag, input logic exp_mp, input logic [31:0] exp_rd);
        #1;
        check({tag, "_mispredict"}, {31'd0, mispredict_e}, {31'd0, exp_mp});
        check({tag, "_redirect"},   redirect_pc_e, exp_rd);
    endtask

    task automatic check_counts(input string tag, input int exp_b, input int exp_m);
        check({tag, "_branch_count"},     branch_count,     32'(exp_b));
        check({tag, "_mispredict_count"}, mispredict_count, 32'(exp_m));
    endtask

    initial begin
        rst = 1'b0;
        pcf = 32'h100;
        idle();

        // In reset: miss, counters zero, mispredict still combinational
        @(negedge clk);
        lookup("rst_lookup", 32'h100, 1'b0, 32'h104);
        check_counts("rst", 0, 0);
        resolve(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        check_exec("rst_exec", 1'b1, 32'h80);
        @(negedge clk);
        check_counts("rst_upd_dropped", 0, 0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        lookup("post_rst", 32'h100, 1'b0, 32'h104);
        check_counts("post_rst", 0, 0);

        // Taken branch at 0x100 allocates with ctr=10
        @(negedge clk);
        resolve(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        check_exec("alloc", 1'b1, 32'h80);
        @(negedge clk);
        idle();
        lookup("alloc_look", 32'h100, 1'b1, 32'h80);
        check_counts("alloc", 1, 1);

        // Not taken twice: 10 -> 01 -> 00
        resolve(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        check_exec("nt1", 1'b1, 32'h104);
        @(negedge clk);
        idle();
        lookup("nt1_look", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        check_exec("nt2", 1'b0, 32'h104);
        @(negedge clk);
        idle();
        check_counts("nt2", 3, 2);

        // Taken from 00 only reaches 01, still predicts not taken
        resolve(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        @(negedge clk);
        idle();
        lookup("sat_low", 32'h100, 1'b0, 32'h104);

        // Same-cycle update and lookup: old contents seen, new target next cycle
        resolve(32'h100, 1'b1, 32'h90, 1'b0, 1'b0, 32'h104);
        lookup("same_cycle", 32'h100, 1'b0, 32'h104);
        @(negedge clk);
        idle();
        lookup("after_update", 32'h100, 1'b1, 32'h90);
        check_counts("same_cycle", 5, 4);

        // Correct taken prediction, then a target-only mispredict
        resolve(32'h100, 1'b1, 32'h90, 1'b0, 1'b1, 32'h90);
        check_exec("tk_ok", 1'b0, 32'h90);
        @(negedge clk);
        resolve(32'h100, 1'b1, 32'hA0, 1'b0, 1'b1, 32'h90);
        check_exec("tgt_wrong", 1'b1, 32'hA0);
        @(negedge clk);
        idle();
        lookup("tgt_new", 32'h100, 1'b1, 32'hA0);
        check_counts("tgt", 7, 5);

        // JAL at 0x200 evicts 0x100 (same index); alias 0x240 misses
        resolve(32'h200, 1'b1, 32'h400, 1'b1, 1'b0, 32'h204);
        check_exec("jal", 1'b1, 32'h400);
        @(negedge clk);
        idle();
        lookup("jal_look", 32'h200, 1'b1, 32'h400);
        lookup("alias",    32'h240, 1'b0, 32'h244);
        lookup("evicted",  32'h100, 1'b0, 32'h104);

        // Jump allocated ctr=11: one not-taken leaves it predicting taken
        resolve(32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
        @(negedge clk);
        idle();
        lookup("jal_ctr11", 32'h200, 1'b1, 32'h400);

        // Miss not taken at aliasing PC: no change to resident entry
        resolve(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
        check_exec("miss_nt", 1'b0, 32'h304);
        @(negedge clk);
        idle();
        lookup("miss_nt_look", 32'h200, 1'b1, 32'h400);
        check_counts("pre_flush", 10, 7);

        // Flush wins over a same-cycle taken update; counters still advance
        resolve(32'h104, 1'b1, 32'h50, 1'b0, 1'b0, 32'h108);
        flush_table = 1'b1;
        @(negedge clk);
        idle();
        lookup("flush_200", 32'h200, 1'b0, 32'h204);
        lookup("flush_104", 32'h104, 1'b0, 32'h108);
        check_counts("flush", 11, 8);

        // Asynchronous reset mid-operation clears counters immediately
        #1 rst = 1'b0;
        #1;
        check_counts("async_rst", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
